// File: rtl/snn_pkg.sv
// snn_pkg: shared types and constants for the SNN output-layer decoder.
//   cls_state_t  - classifier FSM states
//   CLASS_IDX_W  - width of a class index for a given class count
//   DEF_*        - default window length and per-class counter width
package snn_pkg;

    typedef enum logic [1:0] {IDLE, COUNT, ARGMAX, DONE} cls_state_t;

    localparam int DEF_NUM_STEPS = 64;
    localparam int DEF_CNT_WIDTH = 8;

    // A single class still needs one index bit so the port never collapses to zero width.
    function automatic int CLASS_IDX_W(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// sat_counter: clearable up-counter that sticks at all-ones instead of wrapping.
//   clk   - clock, rising edge
//   rst   - asynchronous active-low reset
//   clr   - synchronous clear (wins over inc)
//   inc   - add one when not already saturated
//   count - current value
module sat_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            count <= '0;
        else if (clr)
            count <= '0;
        else if (inc && count != {WIDTH{1'b1}})
            count <= count + 1'b1;
    end

endmodule

// File: rtl/spike_classifier.sv
// spike_classifier: counts output-layer spikes per class over a window, then argmax-scans for the winner.
//   clk, rst               - clock; asynchronous active-low reset
//   start                  - begin a window (IDLE only)
//   en                     - timestep strobe shared with the neuron layer
//   spike_in               - one spike bit per class
//   busy                   - counting or scanning
//   out_valid / out_ready  - result handshake
//   class_out, class_count - winning class and its count
//   no_spike               - all counts were zero
// Build option: SPIKE_CLS_EARLY_EXIT_EN ends the window once any class reaches EARLY_THRESH.
module spike_classifier
    import snn_pkg::*;
#(
    parameter int NUM_CLASSES  = 10,
    parameter int NUM_STEPS    = DEF_NUM_STEPS,
    parameter int CNT_WIDTH    = DEF_CNT_WIDTH,
    parameter int EARLY_THRESH = 16
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                start,
    input  logic                                en,
    input  logic [NUM_CLASSES-1:0]              spike_in,
    output logic                                busy,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic [CLASS_IDX_W(NUM_CLASSES)-1:0] class_out,
    output logic [CNT_WIDTH-1:0]                class_count,
    output logic                                no_spike
);

    localparam int IW = CLASS_IDX_W(NUM_CLASSES);
    localparam int SW = $clog2(NUM_STEPS + 1);
`ifdef SPIKE_CLS_EARLY_EXIT_EN
    localparam bit EARLY_ON = 1'b1;
`else
    localparam bit EARLY_ON = 1'b0;
`endif

    cls_state_t state, state_nxt;

    logic [CNT_WIDTH-1:0]   counts [NUM_CLASSES];
    logic [NUM_CLASSES-1:0] inc;
    logic [NUM_CLASSES-1:0] hit;
    logic [SW-1:0]          step;
    logic [IW-1:0]          idx;
    logic [IW-1:0]          best_idx;
    logic [CNT_WIDTH-1:0]   best_cnt;
    logic [CNT_WIDTH-1:0]   cnt_sel;
    logic [CNT_WIDTH-1:0]   new_cnt;
    logic                   clr;
    logic                   gt;
    logic                   win_end;
    logic                   scan_last;

    assign clr = (state == IDLE) && start;

    for (genvar i = 0; i < NUM_CLASSES; i++) begin : g_cnt
        logic [CNT_WIDTH-1:0] nxt;
        assign inc[i] = (state == COUNT) && en && spike_in[i];
        sat_counter #(.WIDTH(CNT_WIDTH)) u_cnt (
            .clk   (clk),
            .rst   (rst),
            .clr   (clr),
            .inc   (inc[i]),
            .count (counts[i])
        );
        // Threshold is judged on the post-update value, so look one increment ahead.
        assign nxt    = counts[i] + {{(CNT_WIDTH-1){1'b0}}, inc[i] && counts[i] != {CNT_WIDTH{1'b1}}};
        assign hit[i] = int'(nxt) >= EARLY_THRESH;
    end

    assign win_end   = en && ((step == SW'(NUM_STEPS - 1)) || (EARLY_ON && |hit));
    assign scan_last = idx == IW'(NUM_CLASSES - 1);
    assign cnt_sel   = counts[idx];
    assign gt        = cnt_sel > best_cnt;
    assign new_cnt   = gt ? cnt_sel : best_cnt;

    assign busy      = (state == COUNT) || (state == ARGMAX);
    assign out_valid = state == DONE;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    state_nxt = start     ? COUNT  : IDLE;
            COUNT:   state_nxt = win_end   ? ARGMAX : COUNT;
            ARGMAX:  state_nxt = scan_last ? DONE   : ARGMAX;
            DONE:    state_nxt = out_ready ? IDLE   : DONE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            step        <= '0;
            idx         <= '0;
            best_idx    <= '0;
            best_cnt    <= '0;
            class_out   <= '0;
            class_count <= '0;
            no_spike    <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        step        <= '0;
                        idx         <= '0;
                        best_idx    <= '0;
                        best_cnt    <= '0;
                        class_out   <= '0;
                        class_count <= '0;
                        no_spike    <= 1'b0;
                    end
                end
                COUNT: begin
                    idx <= '0;
                    if (en)
                        step <= step + 1'b1;
                end
                ARGMAX: begin
                    // Strictly-greater replacement keeps the lowest index on ties.
                    if (gt) begin
                        best_idx <= idx;
                        best_cnt <= cnt_sel;
                    end
                    idx <= idx + 1'b1;
                    // Publish using the final comparison so the result is ready on DONE entry.
                    if (scan_last) begin
                        class_out   <= gt ? idx : best_idx;
                        class_count <= new_cnt;
                        no_spike    <= new_cnt == '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_spike_classifier.sv
// tb_spike_classifier: directed scoreboard bench for spike_classifier.
module tb_spike_classifier;

    localparam int NC = 10;
    localparam int NS = 9;
    localparam int CW = 3;
    localparam int TH = 2;
    localparam int IW = $clog2(NC);
`ifdef SPIKE_CLS_EARLY_EXIT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    typedef struct packed {
        logic [IW-1:0] idx;
        logic [CW-1:0] cnt;
        logic          nsp;
    } res_t;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic          en = 1'b0;
    logic          out_ready = 1'b0;
    logic [NC-1:0] spike_in = '0;
    logic          busy;
    logic          out_valid;
    logic          no_spike;
    logic [IW-1:0] class_out;
    logic [CW-1:0] class_count;

    res_t sb[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    spike_classifier #(
        .NUM_CLASSES  (NC),
        .NUM_STEPS    (NS),
        .CNT_WIDTH    (CW),
        .EARLY_THRESH (TH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .en          (en),
        .spike_in    (spike_in),
        .busy        (busy),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .class_out   (class_out),
        .class_count (class_count),
        .no_spike    (no_spike)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic spk(input int kind, input int s, input int b);
        case (kind)
            0:       return (b == 3) || (b == 7 && s < 2);
            1:       return (b == 2 && s < 3) || (b == 5 && s >= 3 && s < 6);
            3:       return (b == 1) || (b == 6 && s < 5);
            default: return 1'b0;
        endcase
    endfunction

    task automatic run_window(input int kind, input bit gaps, input bit strays,
                              input int hold, input bit hs_start);
        int            cnt[NC];
        int            s = 0;
        int            c = 0;
        int            best = 0;
        int            bidx = 0;
        bit            fin = 0;
        logic [NC-1:0] v;
        res_t          e;
        foreach (cnt[i]) cnt[i] = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("busy_count", busy, 1);
        while (!fin) begin
            if (gaps && $urandom_range(2, 0) == 0) begin
                en = 1'b0;
                spike_in = NC'($urandom);
                start = strays;
                tick();
                start = 1'b0;
            end else begin
                for (int b = 0; b < NC; b++)
                    v[b] = (kind == 4) ? 1'($urandom_range(1, 0)) : spk(kind, s, b);
                en = 1'b1;
                spike_in = v;
                start = strays && s == 1;
                tick();
                start = 1'b0;
                for (int b = 0; b < NC; b++)
                    if (v[b] && cnt[b] < (1 << CW) - 1) cnt[b]++;
                s++;
                fin = (s == NS);
                if (EARLY)
                    foreach (cnt[i]) if (cnt[i] >= TH) fin = 1;
            end
        end
        en = 1'b0;
        spike_in = NC'($urandom);
        for (int i = 0; i < NC; i++)
            if (cnt[i] > best) begin
                best = cnt[i];
                bidx = i;
            end
        e.idx = IW'(bidx);
        e.cnt = CW'(best);
        e.nsp = (best == 0);
        sb.push_back(e);
        while (!out_valid && c < 50) begin
            tick();
            c++;
        end
        chk("valid_latency", c, NC);
        e = sb.pop_front();
        for (int h = 0; h <= hold; h++) begin
            chk("class_out", class_out, e.idx);
            chk("class_count", class_count, e.cnt);
            chk("no_spike", no_spike, e.nsp);
            chk("valid_hold", out_valid, 1);
            if (h < hold) tick();
        end
        out_ready = 1'b1;
        start = hs_start;
        tick();
        out_ready = 1'b0;
        start = 1'b0;
        chk("valid_after_hs", out_valid, 0);
        chk("busy_after_hs", busy, 0);
        tick();
        chk("idle_stays", busy, 0);
    endtask

    initial begin
        tick();
        tick();
        chk("rst_busy", busy, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_class", class_out, 0);
        chk("rst_count", class_count, 0);
        chk("rst_nospike", no_spike, 0);
        rst = 1'b1;
        tick();
        run_window(0, 1'b0, 1'b0, 0, 1'b0);
        run_window(1, 1'b1, 1'b1, 5, 1'b1);
        run_window(2, 1'b0, 1'b0, 0, 1'b0);
        run_window(3, 1'b1, 1'b0, 1, 1'b0);
        start = 1'b1;
        tick();
        start = 1'b0;
        en = 1'b1;
        spike_in = '1;
        tick();
        chk("busy_before_abort", busy, 1);
        #2;
        rst = 1'b0;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_valid", out_valid, 0);
        chk("abort_class", class_out, 0);
        chk("abort_count", class_count, 0);
        chk("abort_nospike", no_spike, 0);
        en = 1'b0;
        spike_in = '0;
        tick();
        rst = 1'b1;
        tick();
        chk("idle_after_abort", busy, 0);
        run_window(4, 1'b1, 1'b1, 2, 1'b0);
        run_window(4, 1'b0, 1'b0, 0, 1'b0);
        run_window(0, 1'b0, 1'b0, 0, 1'b0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/spike_classifier.md
# spike_classifier

Output-layer decoder for the SNN. It accumulates per-class spike counts from the final neuron layer's `spike_out` bits over a fixed window of timesteps, then selects the winning class by a sequential argmax scan. The result is presented on a valid/ready handshake. It sits directly downstream of the output-layer neurons and shares their `en` timestep strobe.

## Interface
- `NUM_CLASSES`, default 10: number of output neurons / classes.
- `NUM_STEPS`, default 64: timesteps per inference window.
- `CNT_WIDTH`, default 8: width of each per-class spike counter.
- `EARLY_THRESH`, default 16: early-exit count. Used only with `SPIKE_CLS_EARLY_EXIT_EN`.
- `clk  in  1`: clock, rising edge.
- `rst  in  1`: reset, asynchronous, active-low.
- `start  in  1`: single-cycle request to begin a window. Sampled in IDLE only.
- `en  in  1`: timestep strobe. The same signal drives the neuron layer.
- `spike_in  in  NUM_CLASSES`: output-layer spike vector, one bit per class.
- `busy  out  1`: high in COUNT and ARGMAX.
- `out_valid  out  1`: result available. High in DONE only.
- `out_ready  in  1`: consumer accepts the result.
- `class_out  out  $clog2(NUM_CLASSES)`: winning class index.
- `class_count  out  CNT_WIDTH`: spike count of the winning class.
- `no_spike  out  1`: every count was zero. In that case `class_out`=0.

## Operation
- FSM states and transitions:
  - IDLE → COUNT on `start`. This clears all counters, the step counter, the best index and the best count.
  - COUNT → ARGMAX on the edge that samples the final counted `en`.
  - ARGMAX → DONE after NUM_CLASSES scan cycles.
  - DONE → IDLE on `out_valid && out_ready`.
- COUNT, on each cycle with `en`=1:
  - counter[i] += `spike_in[i]` for every i.
  - The step counter increments.
  - Spikes in the final step are counted.
  - `spike_in` is ignored when `en`=0 and in every other state.
- Counters saturate at 2^CNT_WIDTH−1 and never wrap.
- Step counter width is $clog2(NUM_STEPS+1). The window ends when `en`=1 and step == NUM_STEPS−1.
- ARGMAX scans one index per cycle, i = 0..NUM_CLASSES−1.
  - Best is replaced only on a strictly greater count, so ties resolve to the lowest index.
  - Best is initialised to index 0, count 0.
- `no_spike` = (best count == 0) at entry to DONE.
- `start` outside IDLE is ignored; there is no queueing.
- `start` and `out_ready` in the same DONE cycle: `start` is ignored and the FSM returns to IDLE.
- Reset asserted mid-window: immediate abort to IDLE with all state cleared. No partial result is presented.

## Timing
- Reset values: `busy`=0, `out_valid`=0, `class_out`=0, `class_count`=0, `no_spike`=0; state IDLE.
- `start` sampled at edge k: state is COUNT from k; the first `en` counted is at edge k+1 or later.
- Last `en` sampled at edge m: ARGMAX from m, DONE from m+NUM_CLASSES.
  - Therefore `out_valid` rises NUM_CLASSES cycles after the final timestep.
- While `out_valid`=1, `class_out`, `class_count` and `no_spike` are stable. `out_valid` never drops without a handshake.
- Handshake at edge h: `out_valid`=0 after h. The earliest next `start` is sampled at h+1.
- All outputs are registered. There is no combinational path from `out_ready` or `spike_in` to any output.

## Configuration
- `SPIKE_CLS_EARLY_EXIT_EN` defined: in COUNT, if any counter reaches ≥ EARLY_THRESH after an `en` update, COUNT → ARGMAX on that edge, regardless of the step count.
  - The remaining steps are skipped.
  - The argmax is unchanged, so ties still resolve to the lowest index.
- Not defined: the window always runs exactly NUM_STEPS `en` cycles. `EARLY_THRESH` is unused.

## Structure
- Shared package `snn_pkg`:
  - state enum `cls_state_t` {IDLE, COUNT, ARGMAX, DONE};
  - a `CLASS_IDX_W` function of NUM_CLASSES;
  - default NUM_STEPS and CNT_WIDTH constants.
- Sub-module `sat_counter` (parameter WIDTH): a clear/increment saturating counter, instantiated NUM_CLASSES times.

## Test plan
- NUM_CLASSES=10, NUM_STEPS=4. After `start`, `spike_in`=bit 3 on all 4 `en` cycles and bit 7 on 2 of them → `class_out`=3, `class_count`=4, `no_spike`=0. `out_valid` rises 10 cycles after the last `en`.
- Bits 2 and 5 each spike 3 times → `class_out`=2 (lowest-index tie), `class_count`=3.
- `spike_in` all zero for the window → `class_out`=0, `class_count`=0, `no_spike`=1.
- CNT_WIDTH=2, NUM_STEPS=6, bit 1 spiking every step → `class_count`=3 (saturated); no other counter is disturbed.
- `en` gaps, `start` pulses mid-COUNT, `out_ready` held low for 5 cycles in DONE → result is unchanged and stable. The FSM returns to IDLE only on the handshake.
- `rst` pulsed low mid-COUNT → all outputs are 0 immediately (asynchronously). A fresh `start` gives a correct result. With `SPIKE_CLS_EARLY_EXIT_EN`, EARLY_THRESH=2 and bit 4 spiking every step → ARGMAX entered after the 2nd `en`, `class_out`=4.
